// File: rtl/fetch_request_tracker_pkg.sv
// Shared constants and width helpers for the in-flight fetch request tracker.
package fetch_request_tracker_pkg;

    localparam int unsigned DEFAULT_DEPTH         = 4;
    localparam int unsigned DEFAULT_NUM_SUB_UNITS = 3;
    localparam int unsigned DEFAULT_ID_W          = 3;
    localparam int unsigned INSN_W                = 32;

    function automatic int unsigned sub_width(input int unsigned num_sub_units);
        return (num_sub_units == 1) ? 1 : $clog2(num_sub_units);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_request_tracker_if.sv
// Issue/response bundle between fetch issue logic, the sub-units and the tracker.
interface fetch_request_tracker_if
    import fetch_request_tracker_pkg::*;
#(
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned NUM_SUB_UNITS = DEFAULT_NUM_SUB_UNITS,
    parameter int unsigned ID_W          = DEFAULT_ID_W
);
    localparam int unsigned SUB_W = sub_width(NUM_SUB_UNITS);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    // req_push is a one-cycle issue strobe, legal only while full is low;
    // rsp_valid/rsp_discard have no ready: the head retires the cycle they are high.
    logic                            flush;
    logic                            req_push;
    logic [SUB_W-1:0]                req_subunit;
    logic                            req_addr_valid;
    logic                            req_mmu_fault;
    logic [31:0]                     req_pc;
    logic [ID_W-1:0]                 req_id;
    logic                            req_pred;
    logic [NUM_SUB_UNITS-1:0]        unit_data_valid;
    logic [NUM_SUB_UNITS*INSN_W-1:0] unit_data;

    logic                            full;
    logic [CNT_W-1:0]                inflight;
    logic                            drained;
    logic                            rsp_valid;
    logic [INSN_W-1:0]               rsp_instruction;
    logic [31:0]                     rsp_pc;
    logic [ID_W-1:0]                 rsp_id;
    logic                            rsp_ok;
    logic                            rsp_page_fault;
    logic                            rsp_pred;
    logic                            rsp_discard;

    modport master (
        output flush, req_push, req_subunit, req_addr_valid, req_mmu_fault,
               req_pc, req_id, req_pred, unit_data_valid, unit_data,
        input  full, inflight, drained, rsp_valid, rsp_instruction, rsp_pc,
               rsp_id, rsp_ok, rsp_page_fault, rsp_pred, rsp_discard
    );

    modport slave (
        input  flush, req_push, req_subunit, req_addr_valid, req_mmu_fault,
               req_pc, req_id, req_pred, unit_data_valid, unit_data,
        output full, inflight, drained, rsp_valid, rsp_instruction, rsp_pc,
               rsp_id, rsp_ok, rsp_page_fault, rsp_pred, rsp_discard
    );

endinterface

// File: rtl/fetch_request_tracker.sv
// In-order tracker of outstanding fetches: records request attributes, steers the
// returning sub-unit word to decode and squashes flushed requests via per-entry stale bits.
module fetch_request_tracker
    import fetch_request_tracker_pkg::*;
#(
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned NUM_SUB_UNITS = DEFAULT_NUM_SUB_UNITS,
    parameter int unsigned ID_W          = DEFAULT_ID_W,
    parameter bit          CHECK_FAULTS  = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    fetch_request_tracker_if.slave bus
);
    localparam int unsigned SUB_W   = sub_width(NUM_SUB_UNITS);
    localparam int unsigned CNT_W   = cnt_width(DEPTH);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned SUB_PAD = 1 << SUB_W;

    logic [SUB_W-1:0]  sub_q [DEPTH];
    logic [31:0]       pc_q  [DEPTH];
    logic [ID_W-1:0]   id_q  [DEPTH];
    logic [DEPTH-1:0]  addr_valid_q;
    logic [DEPTH-1:0]  mmu_fault_q;
    logic [DEPTH-1:0]  pred_q;
    logic [DEPTH-1:0]  stale_q, stale_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Padding to a power of two keeps an out-of-range sub-unit index from reading X.
    logic [SUB_PAD-1:0]        udv_pad;
    logic [SUB_PAD*INSN_W-1:0] data_pad;

    logic [SUB_W-1:0] head_sub;
    logic             head_needs_data;
    logic             head_complete;
    logic             empty;
    logic             push;
    logic             pop;

    assign udv_pad  = SUB_PAD'(bus.unit_data_valid);
    assign data_pad = (SUB_PAD*INSN_W)'(bus.unit_data);

    assign empty           = (count_q == '0);
    assign head_sub        = sub_q[rd_ptr_q];
    assign head_needs_data = CHECK_FAULTS ? (addr_valid_q[rd_ptr_q] & ~mmu_fault_q[rd_ptr_q]) : 1'b1;
    assign head_complete   = ~empty & (~head_needs_data | udv_pad[head_sub]);
    assign push            = bus.req_push;
    assign pop             = head_complete;

    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Flush marks every slot; slots that are not live get cleared again when pushed.
    always_comb begin
        stale_d = stale_q;
        if (push)      stale_d[wr_ptr_q] = 1'b0;
        if (bus.flush) stale_d = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stale_q      <= '0;
            addr_valid_q <= '0;
            mmu_fault_q  <= '0;
            pred_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sub_q[i] <= '0;
                pc_q[i]  <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stale_q  <= stale_d;
            if (push) begin
                sub_q[wr_ptr_q]        <= bus.req_subunit;
                pc_q[wr_ptr_q]         <= bus.req_pc;
                id_q[wr_ptr_q]         <= bus.req_id;
                addr_valid_q[wr_ptr_q] <= bus.req_addr_valid;
                mmu_fault_q[wr_ptr_q]  <= bus.req_mmu_fault;
                pred_q[wr_ptr_q]       <= bus.req_pred;
            end
        end
    end

    assign bus.full            = (count_q == CNT_W'(DEPTH));
    assign bus.inflight        = count_q;
    assign bus.drained         = (count_d == '0);
    assign bus.rsp_valid       = head_complete & ~stale_q[rd_ptr_q];
    assign bus.rsp_discard     = head_complete & stale_q[rd_ptr_q];
    assign bus.rsp_instruction = data_pad[INSN_W*head_sub +: INSN_W];
    assign bus.rsp_pc          = pc_q[rd_ptr_q];
    assign bus.rsp_id          = id_q[rd_ptr_q];
    assign bus.rsp_ok          = CHECK_FAULTS ? (addr_valid_q[rd_ptr_q] & ~mmu_fault_q[rd_ptr_q]) : 1'b1;
    assign bus.rsp_page_fault  = mmu_fault_q[rd_ptr_q];
    assign bus.rsp_pred        = pred_q[rd_ptr_q];

    a_push_while_full: assert property (@(posedge clk) disable iff (rst)
        !(bus.req_push && bus.full));

    a_spurious_fetch_complete: assert property (@(posedge clk) disable iff (rst)
        (|bus.unit_data_valid) |-> (!empty && (udv_pad == (SUB_PAD'(1) << head_sub))));

    a_single_responder: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.unit_data_valid));

endmodule
